// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared flag/entry types and default sizes for the reorder buffer
package reorder_buffer_pkg;
  localparam int GPR_SIZE = 64;
  localparam int GPR_IDX_SIZE = 5;
  localparam int ROB_SIZE = 8;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
  typedef struct packed {
    logic valid;
    logic done;
    logic writes_gpr;
    logic set_nzcv;
    logic [GPR_IDX_SIZE-1:0] gpr_idx;
    logic [GPR_SIZE-1:0] value;
    nzcv_t nzcv;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, writeback, commit and forwarding bundle of the reorder buffer
interface reorder_buffer_if import reorder_buffer_pkg::*; #(
  parameter int DEPTH = ROB_SIZE,
  parameter int VALUE_W = GPR_SIZE,
  parameter int GPR_IDX_W = GPR_IDX_SIZE,
  parameter int IDX_W = $clog2(DEPTH)
);
  logic alloc_valid;
  logic [GPR_IDX_W-1:0] alloc_gpr_idx;
  logic alloc_writes_gpr;
  logic alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic fu_done;
  logic [IDX_W-1:0] fu_rob_idx;
  logic [VALUE_W-1:0] fu_value;
  logic fu_set_nzcv;
  nzcv_t fu_nzcv;
  logic fu_mispred;
  logic commit_valid;
  logic [GPR_IDX_W-1:0] commit_gpr_idx;
  logic commit_writes_gpr;
  logic [VALUE_W-1:0] commit_value;
  nzcv_t arch_nzcv;
  logic flush_valid;
  logic [IDX_W:0] count;
  logic [IDX_W-1:0] fwd_rob_idx;
  logic fwd_valid;
  logic [VALUE_W-1:0] fwd_value;
  modport master (
    output alloc_valid, alloc_gpr_idx, alloc_writes_gpr, fu_done, fu_rob_idx, fu_value,
           fu_set_nzcv, fu_nzcv, fu_mispred, fwd_rob_idx,
    input  alloc_ready, alloc_idx, commit_valid, commit_gpr_idx, commit_writes_gpr,
           commit_value, arch_nzcv, flush_valid, count, fwd_valid, fwd_value
  );
  modport slave (
    input  alloc_valid, alloc_gpr_idx, alloc_writes_gpr, fu_done, fu_rob_idx, fu_value,
           fu_set_nzcv, fu_nzcv, fu_mispred, fwd_rob_idx,
    output alloc_ready, alloc_idx, commit_valid, commit_gpr_idx, commit_writes_gpr,
           commit_value, arch_nzcv, flush_valid, count, fwd_valid, fwd_value
  );
endinterface

// File: rtl/reorder_buffer_fwd_lookup.sv
// reorder_buffer_fwd_lookup: combinational read of a completed entry's result for operand forwarding
module reorder_buffer_fwd_lookup #(
  parameter int DEPTH = 8,
  parameter int VALUE_W = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] done,
  input  logic [VALUE_W-1:0] value [DEPTH],
  input  logic [IDX_W-1:0] idx,
  output logic fwd_valid,
  output logic [VALUE_W-1:0] fwd_value
);
  assign fwd_valid = valid[idx] & done[idx];
  assign fwd_value = fwd_valid ? value[idx] : '0;
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order allocate/retire, out-of-order writeback, one-cycle squash; ROB_FORWARD_EN adds a forwarding read port
module reorder_buffer import reorder_buffer_pkg::*; #(
  parameter int DEPTH = ROB_SIZE,
  parameter int VALUE_W = GPR_SIZE,
  parameter int GPR_IDX_W = GPR_IDX_SIZE,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  reorder_buffer_if.slave rob
);
  logic [DEPTH-1:0] valid, done, writes_gpr, set_nzcv, kill;
  logic [GPR_IDX_W-1:0] gpr [DEPTH];
  logic [VALUE_W-1:0] value [DEPTH];
  nzcv_t nzcv [DEPTH];
  logic [IDX_W-1:0] head, tail, k1, span;
  logic [IDX_W:0] count, flush_count;
  nzcv_t arch_nzcv;
  logic flush_q, full, alloc_fire, wb, flush, commit;
  assign full = count == (IDX_W+1)'(DEPTH);
  assign commit = valid[head] & done[head];
  assign alloc_fire = rob.alloc_valid & rob.alloc_ready;
  assign wb = rob.fu_done & valid[rob.fu_rob_idx];
  assign flush = wb & rob.fu_mispred;
  assign k1 = rob.fu_rob_idx + IDX_W'(1);
  assign span = k1 - head;
  // zero span means the squashing branch is the youngest of a full buffer
  assign flush_count = span == '0 ? (IDX_W+1)'(DEPTH) : {1'b0, span};
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) kill[i] = (IDX_W'(i) - k1) < (tail - k1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      arch_nzcv <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush;
      if (commit) head <= head + IDX_W'(1);
      if (commit && set_nzcv[head]) arch_nzcv <= nzcv[head];
      tail <= flush ? k1 : alloc_fire ? tail + IDX_W'(1) : tail;
      count <= flush ? flush_count - (IDX_W+1)'(commit)
                     : count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit);
      valid <= (valid & ~(flush ? kill : '0) & ~(DEPTH'(commit) << head)) | (DEPTH'(alloc_fire) << tail);
    end
  end
  // payload needs no reset: every read is qualified by valid
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      done[tail] <= 1'b0;
      set_nzcv[tail] <= 1'b0;
      writes_gpr[tail] <= rob.alloc_writes_gpr;
      gpr[tail] <= rob.alloc_gpr_idx;
    end
    if (wb) begin
      done[rob.fu_rob_idx] <= 1'b1;
      value[rob.fu_rob_idx] <= rob.fu_value;
    end
    if (wb && rob.fu_set_nzcv) begin
      set_nzcv[rob.fu_rob_idx] <= 1'b1;
      nzcv[rob.fu_rob_idx] <= rob.fu_nzcv;
    end
  end
  assign rob.alloc_ready = !full && !rob.fu_mispred;
  assign rob.alloc_idx = tail;
  assign rob.commit_valid = commit;
  assign rob.commit_gpr_idx = commit ? gpr[head] : '0;
  assign rob.commit_writes_gpr = commit & writes_gpr[head];
  assign rob.commit_value = commit ? value[head] : '0;
  assign rob.arch_nzcv = arch_nzcv;
  assign rob.flush_valid = flush_q;
  assign rob.count = count;
`ifdef ROB_FORWARD_EN
  reorder_buffer_fwd_lookup #(.DEPTH(DEPTH), .VALUE_W(VALUE_W), .IDX_W(IDX_W)) u_fwd (
    .valid(valid),
    .done(done),
    .value(value),
    .idx(rob.fwd_rob_idx),
    .fwd_valid(rob.fwd_valid),
    .fwd_value(rob.fwd_value)
  );
`else
  logic unused_fwd;
  assign unused_fwd = ^rob.fwd_rob_idx;
  assign rob.fwd_valid = 1'b0;
  assign rob.fwd_value = '0;
`endif
endmodule
